// File: rtl/reg_read_port.sv
// Read-side sequencer for the general register file: drives one-hot register selects and returns operands over valid/ready.
// Optional feature: define READ_BYPASS_EN to forward an in-flight register write into the captured operand.
module reg_read_port #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_ra,
  input  logic [IDX_W-1:0]    req_rb,
  input  logic                req_two,
  input  logic                req_ba,
  output logic [NUM_REGS-1:0] rf_sel,
  input  logic [DATA_W-1:0]   rf_data,
`ifdef READ_BYPASS_EN
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_a,
  output logic [DATA_W-1:0]   rsp_b
);

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, RESP} state_t;

  state_t            state;
  logic [IDX_W-1:0]  ra_q;
  logic [IDX_W-1:0]  rb_q;
  logic              two_q;
  logic              ba_q;

  // With base-address semantics R0 is never put on the bus.
  function automatic logic [NUM_REGS-1:0] sel_of(input logic [IDX_W-1:0] idx,
                                                 input logic ba);
    logic [NUM_REGS-1:0] s;
    s = '0;
    if (!(ba && idx == '0))
      s[idx] = 1'b1;
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic [IDX_W-1:0]  idx,
                                             input logic              ba,
                                             input logic [DATA_W-1:0] bus);
    logic [DATA_W-1:0] v;
    v = bus;
`ifdef READ_BYPASS_EN
    if (wr_en && wr_idx == idx)
      v = wr_data;
`endif
    // The zero rule outranks any forwarded write.
    if (ba && idx == '0)
      v = '0;
    return v;
  endfunction

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rf_sel    <= '0;
      rsp_valid <= 1'b0;
      rsp_a     <= '0;
      rsp_b     <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      two_q     <= 1'b0;
      ba_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ra_q      <= req_ra;
            rb_q      <= req_rb;
            two_q     <= req_two;
            ba_q      <= req_ba;
            rf_sel    <= sel_of(req_ra, req_ba);
            req_ready <= 1'b0;
            state     <= RD_A;
          end
        end
        RD_A: begin
          rsp_a <= pick(ra_q, ba_q, rf_data);
          if (two_q) begin
            rf_sel <= sel_of(rb_q, ba_q);
            state  <= RD_B;
          end else begin
            rsp_b     <= '0;
            rf_sel    <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RD_B: begin
          rsp_b     <= pick(rb_q, ba_q, rf_data);
          rf_sel    <= '0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rf_sel    <= '0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_read_port.sv
// Scoreboard bench for reg_read_port: a register-file model answers the selects, a monitor checks responses.
module tb_reg_read_port;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_ra = '0;
  logic [3:0]  req_rb = '0;
  logic        req_two = 1'b0;
  logic        req_ba = 1'b0;
  logic [15:0] rf_sel;
  logic [31:0] rf_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_a;
  logic [31:0] rsp_b;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_idx = '0;
  logic [31:0] wr_data = '0;

  logic [31:0] regs [16];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          prev_valid = 0;
  logic [31:0] last_a = '0;

`ifdef READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_read_port #(.DATA_W(32), .NUM_REGS(16), .IDX_W(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ra    (req_ra),
    .req_rb    (req_rb),
    .req_two   (req_two),
    .req_ba    (req_ba),
    .rf_sel    (rf_sel),
    .rf_data   (rf_data),
`ifdef READ_BYPASS_EN
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_a     (rsp_a),
    .rsp_b     (rsp_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Register file model: the bus carries whichever registers are selected.
  always_comb begin
    rf_data = '0;
    for (int i = 0; i < 16; i++)
      if (rf_sel[i]) rf_data = rf_data | regs[i];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_val(input logic [3:0] idx, input logic ba);
    if (ba && idx == 4'd0) return 32'd0;
    if (BYPASS && wr_en && wr_idx == idx) return wr_data;
    return regs[idx];
  endfunction

  function automatic logic [15:0] ref_sel(input logic [3:0] idx, input logic ba);
    if (ba && idx == 4'd0) return 16'd0;
    return 16'd1 << idx;
  endfunction

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (clr) begin
      prev_valid = 0;
    end else begin
      chk("rf_sel_onehot", 32'(($countones(rf_sel) <= 1)), 32'd1);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got rsp_a %h rsp_b %h, expected no response", rsp_a, rsp_b);
        end else begin
          if (!prev_valid) chk("latency", cyc, exp_q[0].due);
          chk("rsp_a", rsp_a, exp_q[0].a);
          chk("rsp_b", rsp_b, exp_q[0].b);
          chk("rf_sel_resp", 32'(rf_sel), 32'd0);
          if (rsp_ready) begin
            last_a = exp_q[0].a;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  // Entered and left at posedge+1; hold=0 keeps rsp_ready high from the start.
  task automatic do_req(input logic [3:0] ra, input logic [3:0] rb, input logic two,
                        input logic ba, input int hold);
    int t;
    exp_t e;
    t = 0;
    while (!req_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    if (!req_ready) return;
    req_valid = 1'b1;
    req_ra = ra;
    req_rb = rb;
    req_two = two;
    req_ba = ba;
    rsp_ready = (hold == 0);
    e.a = ref_val(ra, ba);
    e.b = two ? ref_val(rb, ba) : 32'd0;
    e.due = cyc + (two ? 3 : 2);
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_ra = 4'($urandom);
    req_rb = 4'($urandom);
    chk("rf_sel_a", 32'(rf_sel), 32'(ref_sel(ra, ba)));
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (two) begin
      @(posedge clk); #1;
      chk("rf_sel_b", 32'(rf_sel), 32'(ref_sel(rb, ba)));
    end
    t = 0;
    while (!rsp_valid && t < 8) begin
      @(posedge clk); #1;
      t++;
    end
    chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_ra = 4'($urandom);
      req_two = 1'($urandom);
      @(posedge clk); #1;
      chk("req_ready_resp", 32'(req_ready), 32'd0);
      chk("rsp_valid_hold", 32'(rsp_valid), 32'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("req_ready_after", 32'(req_ready), 32'd1);
    chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk("rsp_a_kept", rsp_a, last_a);
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rf_sel", 32'(rf_sel), 32'd0);
    chk("rst_rsp_a", rsp_a, 32'd0);
    chk("rst_rsp_b", rsp_b, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;

    regs[5] = 32'hDEADBEEF;
    do_req(4'd5, 4'd0, 1'b0, 1'b0, 0);
    chk("dir_single_a", rsp_a, 32'hDEADBEEF);
    chk("dir_single_b", rsp_b, 32'd0);

    regs[0] = 32'h1234;
    regs[7] = 32'h55;
    do_req(4'd0, 4'd7, 1'b1, 1'b1, 0);
    chk("dir_ba_a", rsp_a, 32'd0);
    chk("dir_ba_b", rsp_b, 32'h55);
    do_req(4'd0, 4'd7, 1'b1, 1'b0, 0);
    chk("dir_noba_a", rsp_a, 32'h1234);

    do_req(4'd7, 4'd7, 1'b1, 1'b0, 5);
    do_req(4'd3, 4'd9, 1'b0, 1'b1, 0);

`ifdef READ_BYPASS_EN
    regs[3] = 32'd1;
    wr_en = 1'b1; wr_idx = 4'd3; wr_data = 32'd9;
    do_req(4'd3, 4'd0, 1'b0, 1'b0, 0);
    chk("bypass_a", rsp_a, 32'd9);
    wr_en = 1'b1; wr_idx = 4'd0; wr_data = 32'd9;
    do_req(4'd0, 4'd0, 1'b0, 1'b1, 0);
    chk("bypass_ba_a", rsp_a, 32'd0);
`endif

    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      if (BYPASS) begin
        wr_en = 1'($urandom);
        wr_idx = 4'($urandom);
        wr_data = $urandom;
      end
      do_req(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of the second read aborts the request.
    req_valid = 1'b1; req_ra = 4'd2; req_rb = 4'd4; req_two = 1'b1; req_ba = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_rd_b", 32'(rf_sel), 32'h0010);
    #2;
    clr = 1'b1;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rf_sel", 32'(rf_sel), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    clr = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_b", rsp_b, 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
